sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (inst, master 0) and the load/store requester (data, master 1).
- Sits between the pipeline's inst/data sram-like interfaces and the single sram-like-to-AXI bridge.
- Arbitrates address phases and tracks outstanding transactions in issue order.
- Routes each data_ok/rdata back to the master that issued the matching request.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions; a power of 2, from 1 to 8.
- ID_FIFO_AW, 1, log2(OUTSTANDING); minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  inst request; held stable until inst_addr_ok.
- inst_wr  in  1  inst write flag; always 0 in practice, passed through.
- inst_size  in  2  access size: 0=byte, 1=half, 2=word.
- inst_wstrb  in  4  byte write strobes.
- inst_addr  in  32  inst request address.
- inst_wdata  in  32  inst write data.
- inst_addr_ok  out  1  inst address phase accepted.
- inst_data_ok  out  1  inst response valid.
- inst_rdata  out  32  inst response data.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  same as inst_*, for the data master.
- data_addr_ok, data_data_ok, data_rdata  out  1/1/32  same as inst_*, for the data master.
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  to the shared port.
- mem_addr_ok, mem_data_ok  in  1/1  handshakes from the shared port.
- mem_rdata  in  32  response data from the shared port.
- resp_err  out  1  sticky flag: a response arrived with no outstanding transaction recorded.

Behaviour:
- Reset (resetn low, asynchronous):
  - lock cleared, grant=0, ID FIFO emptied, resp_err cleared.
  - All *_addr_ok, *_data_ok and mem_req drive 0.
  - mem_* payload outputs and *_rdata are don't-care but must be X-free; drive 0.
  - Any in-flight transaction is abandoned; responses for it arriving after reset count as spurious and set resp_err.
- Grant selection, combinational, when lock=0:
  - data_req has priority over inst_req.
  - grant = data_req ? 1 : 0; candidate valid = inst_req | data_req.
- Lock register:
  - Set when mem_req=1 and mem_addr_ok=0; stores grant.
  - Cleared on the cycle mem_addr_ok=1.
  - While lock=1 the stored grant is used regardless of the other request, which keeps the mem_* request stable as sram-like requires.
- Shared port request:
  - mem_req = (requester for the selected master) & ~fifo_full.
  - mem_* payload muxed from the selected master.
- Address-phase acceptance:
  - The selected master's addr_ok = mem_addr_ok & mem_req.
  - The other master's addr_ok = 0.
- FIFO:
  - Push the selected ID on mem_req & mem_addr_ok.
  - Pop on mem_data_ok when non-empty.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Pointers wrap modulo OUTSTANDING.
  - A count register of width ID_FIFO_AW+1 distinguishes full from empty.
- Full: fifo_full blocks mem_req entirely. lock is held.
- Empty:
  - A mem_data_ok with the FIFO empty sets resp_err.
  - No *_data_ok is asserted for it and no pop occurs.
- Response routing (combinational, zero added latency):
  - head ID 0 -> inst_data_ok = mem_data_ok, inst_rdata = mem_rdata.
  - head ID 1 -> the same to data_data_ok/data_rdata.
  - The non-head master sees data_ok=0 and rdata=0.
- Responses return in issue order; the block does not reorder.
- A response and a new acceptance in the same cycle are both legal.
- Starvation: inst is starved only while data_req is continuously high. No fairness counter is required.

Test Plan:
- Single inst read: inst_req=1, addr=0x1c000000, mem_addr_ok=1 at cycle 1, mem_data_ok=1 with rdata=0x02800421 at cycle 3 -> inst_addr_ok=1 at cycle 1; inst_data_ok=1 and inst_rdata=0x02800421 at cycle 3; data_* outputs stay 0.
- Simultaneous requests: inst_req=1 and data_req=1 at cycle 0 -> data granted first (mem_addr=data_addr); inst accepted on the next mem_addr_ok; responses 0xAAAA0000 then 0x5555FFFF route to data then inst.
- Lock stability: inst_req granted with mem_addr_ok=0 for 3 cycles, then data_req rises at cycle 1 -> mem_addr stays inst_addr until accepted; data granted afterwards.
- Full FIFO (OUTSTANDING=2): two accepted requests with no data_ok, third request pending -> mem_req=0 until the first mem_data_ok. Then the third is accepted and the count stays 2.
- Same-cycle push and pop: count=1, mem_addr_ok and mem_data_ok both high -> count stays 1, head advances, new ID queued correctly.
- Spurious response and async reset: mem_data_ok with the FIFO empty -> resp_err=1, no *_data_ok. Then resetn pulled low mid-transaction, asynchronously between edges -> all outputs 0 immediately and resp_err cleared.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: request/payload from the master, handshakes and read data back from the slave.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between inst (ID 0) and data (ID 1) masters,
// with an in-order ID FIFO that steers each response back to its issuer.
module sram_like_arbiter #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned ID_FIFO_AW  = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_like_arbiter_if.slave   inst,
    sram_like_arbiter_if.slave   data,
    sram_like_arbiter_if.master  mem,
    output logic                 resp_err
);
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t               state, state_next;
    logic                      lock_grant, lock_grant_next;
    logic                      grant;
    logic                      req_sel;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic                      head_id;
    logic [ID_FIFO_AW:0]       count;
    logic [ID_FIFO_AW-1:0]     wr_ptr;
    logic [ID_FIFO_AW-1:0]     rd_ptr;
    logic                      id_mem [OUTSTANDING];

    function automatic logic [ID_FIFO_AW-1:0] ptr_inc(input logic [ID_FIFO_AW-1:0] p);
        return (32'(p) == OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    // A pending-but-unaccepted request pins the grant so mem_* stays stable.
    assign grant   = (state == LOCKED) ? lock_grant : data.req;
    assign req_sel = grant ? data.req : inst.req;
    assign full    = (count == (ID_FIFO_AW + 1)'(OUTSTANDING));
    assign empty   = (count == '0);
    assign mem.req = resetn & req_sel & ~full;
    assign push    = mem.req & mem.addr_ok;
    assign pop     = mem.data_ok & ~empty;
    assign head_id = id_mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= UNLOCKED;
            lock_grant <= 1'b0;
        end else begin
            state      <= state_next;
            lock_grant <= lock_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        lock_grant_next = lock_grant;
        case (state)
            UNLOCKED: begin
                if (mem.req && !mem.addr_ok) begin
                    state_next      = LOCKED;
                    lock_grant_next = grant;
                end
            end
            LOCKED: begin
                if (mem.addr_ok) state_next = UNLOCKED;
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_comb begin
        mem.wr    = 1'b0;
        mem.size  = '0;
        mem.wstrb = '0;
        mem.addr  = '0;
        mem.wdata = '0;
        if (resetn) begin
            mem.wr    = grant ? data.wr    : inst.wr;
            mem.size  = grant ? data.size  : inst.size;
            mem.wstrb = grant ? data.wstrb : inst.wstrb;
            mem.addr  = grant ? data.addr  : inst.addr;
            mem.wdata = grant ? data.wdata : inst.wdata;
        end
    end

    assign inst.addr_ok = push & ~grant;
    assign data.addr_ok = push & grant;

    assign inst.data_ok = pop & ~head_id;
    assign data.data_ok = pop & head_id;
    assign inst.rdata   = (!empty && !head_id) ? mem.rdata : '0;
    assign data.rdata   = (!empty &&  head_id) ? mem.rdata : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            resp_err <= 1'b0;
            for (int unsigned i = 0; i < OUTSTANDING; i++) id_mem[i] <= 1'b0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= grant;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mem.data_ok && empty) resp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scenario bench for sram_like_arbiter: a scoreboard records the expected owner and
// data of every accepted request and is drained as the bench returns responses.
module tb_sram_like_arbiter;
    logic clk;
    logic resetn;
    logic resp_err;

    sram_like_arbiter_if inst_bus ();
    sram_like_arbiter_if data_bus ();
    sram_like_arbiter_if mem_bus ();

    sram_like_arbiter #(
        .OUTSTANDING(2),
        .ID_FIFO_AW (1)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .inst    (inst_bus),
        .data    (data_bus),
        .mem     (mem_bus),
        .resp_err(resp_err)
    );

    typedef struct packed {
        logic        who;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2'd2; inst_bus.wstrb = 4'h0;
        inst_bus.addr = 32'h0; inst_bus.wdata = 32'h0;
        data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2'd2; data_bus.wstrb = 4'h0;
        data_bus.addr = 32'h0; data_bus.wdata = 32'h0;
        mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 32'h0;
    endtask

    task automatic test_reset();
        resetn = 0;
        clear_inputs();
        inst_bus.req = 1; inst_bus.addr = 32'h1c000000;
        data_bus.req = 1; data_bus.addr = 32'h80000000;
        mem_bus.addr_ok = 1;
        #1;
        checks++;
        if (mem_bus.req !== 1'b0 || mem_bus.addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem: mem_req=%b mem_addr=%h required 0/0", mem_bus.req, mem_bus.addr);
        end
        checks++;
        if ({inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok, resp_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: ok/err=%b required 00000",
                     {inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok, resp_err});
        end
        clear_inputs();
        next_cycle();
        resetn = 1;
        next_cycle();
    endtask

    task automatic test_single_inst();
        inst_bus.req = 1; inst_bus.addr = 32'h1c000000;
        #1;
        checks++;
        if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h1c000000 || inst_bus.addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL single_c0: mem_req=%b mem_addr=%h inst_addr_ok=%b required 1/1c000000/0",
                     mem_bus.req, mem_bus.addr, inst_bus.addr_ok);
        end
        next_cycle();
        mem_bus.addr_ok = 1;
        #1;
        checks++;
        if (inst_bus.addr_ok !== 1'b1 || data_bus.addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL single_accept: inst_addr_ok=%b data_addr_ok=%b required 1/0",
                     inst_bus.addr_ok, data_bus.addr_ok);
        end
        sb.push_back('{who: 1'b0, rdata: 32'h02800421});
        next_cycle();
        inst_bus.req = 0; mem_bus.addr_ok = 0;
        #1;
        checks++;
        if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) begin
            failures++;
            $display("FAIL single_wait: inst_data_ok=%b data_data_ok=%b required 0/0",
                     inst_bus.data_ok, data_bus.data_ok);
        end
        next_cycle();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            mem_bus.data_ok = 1; mem_bus.rdata = e.rdata;
            #1;
            checks++;
            if (inst_bus.data_ok !== ~e.who || data_bus.data_ok !== e.who) begin
                failures++;
                $display("FAIL single_route: inst_data_ok=%b data_data_ok=%b required owner %0d",
                         inst_bus.data_ok, data_bus.data_ok, e.who);
            end
            checks++;
            if ((e.who ? data_bus.rdata : inst_bus.rdata) !== e.rdata ||
                (e.who ? inst_bus.rdata : data_bus.rdata) !== 32'h0) begin
                failures++;
                $display("FAIL single_rdata: inst_rdata=%h data_rdata=%h required %h to owner %0d",
                         inst_bus.rdata, data_bus.rdata, e.rdata, e.who);
            end
            next_cycle();
            mem_bus.data_ok = 0;
        end
    endtask

    task automatic test_simultaneous();
        inst_bus.req = 1; inst_bus.addr = 32'h1c000100;
        data_bus.req = 1; data_bus.addr = 32'h80001000;
        mem_bus.addr_ok = 1;
        #1;
        checks++;
        if (mem_bus.addr !== 32'h80001000 || data_bus.addr_ok !== 1'b1 || inst_bus.addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL simul_data_first: mem_addr=%h data_addr_ok=%b inst_addr_ok=%b required 80001000/1/0",
                     mem_bus.addr, data_bus.addr_ok, inst_bus.addr_ok);
        end
        sb.push_back('{who: 1'b1, rdata: 32'hAAAA0000});
        next_cycle();
        data_bus.req = 0;
        #1;
        checks++;
        if (mem_bus.addr !== 32'h1c000100 || inst_bus.addr_ok !== 1'b1 || data_bus.addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL simul_inst_second: mem_addr=%h inst_addr_ok=%b data_addr_ok=%b required 1c000100/1/0",
                     mem_bus.addr, inst_bus.addr_ok, data_bus.addr_ok);
        end
        sb.push_back('{who: 1'b0, rdata: 32'h5555FFFF});
        next_cycle();
        inst_bus.req = 0; mem_bus.addr_ok = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            mem_bus.data_ok = 1; mem_bus.rdata = e.rdata;
            #1;
            checks++;
            if (inst_bus.data_ok !== ~e.who || data_bus.data_ok !== e.who ||
                (e.who ? data_bus.rdata : inst_bus.rdata) !== e.rdata ||
                (e.who ? inst_bus.rdata : data_bus.rdata) !== 32'h0) begin
                failures++;
                $display("FAIL simul_route: ok=%b%b rdata=%h/%h required owner %0d data %h",
                         inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata, data_bus.rdata, e.who, e.rdata);
            end
            next_cycle();
            mem_bus.data_ok = 0;
        end
    endtask

    task automatic test_lock();
        inst_bus.req = 1; inst_bus.addr = 32'h1c000200;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                data_bus.req = 1; data_bus.addr = 32'h80002000;
            end
            #1;
            checks++;
            if (mem_bus.addr !== 32'h1c000200 || mem_bus.req !== 1'b1 || data_bus.addr_ok !== 1'b0) begin
                failures++;
                $display("FAIL lock_hold c%0d: mem_addr=%h mem_req=%b data_addr_ok=%b required 1c000200/1/0",
                         c, mem_bus.addr, mem_bus.req, data_bus.addr_ok);
            end
            next_cycle();
        end
        mem_bus.addr_ok = 1;
        #1;
        checks++;
        if (mem_bus.addr !== 32'h1c000200 || inst_bus.addr_ok !== 1'b1 || data_bus.addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL lock_accept: mem_addr=%h inst_addr_ok=%b data_addr_ok=%b required 1c000200/1/0",
                     mem_bus.addr, inst_bus.addr_ok, data_bus.addr_ok);
        end
        sb.push_back('{who: 1'b0, rdata: 32'h12345678});
        next_cycle();
        inst_bus.req = 0;
        #1;
        checks++;
        if (mem_bus.addr !== 32'h80002000 || data_bus.addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL lock_then_data: mem_addr=%h data_addr_ok=%b required 80002000/1",
                     mem_bus.addr, data_bus.addr_ok);
        end
        sb.push_back('{who: 1'b1, rdata: 32'h9abcdef0});
        next_cycle();
        data_bus.req = 0; mem_bus.addr_ok = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            mem_bus.data_ok = 1; mem_bus.rdata = e.rdata;
            #1;
            checks++;
            if (inst_bus.data_ok !== ~e.who || data_bus.data_ok !== e.who ||
                (e.who ? data_bus.rdata : inst_bus.rdata) !== e.rdata) begin
                failures++;
                $display("FAIL lock_route: ok=%b%b rdata=%h/%h required owner %0d data %h",
                         inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata, data_bus.rdata, e.who, e.rdata);
            end
            next_cycle();
            mem_bus.data_ok = 0;
        end
    endtask

    task automatic test_full();
        inst_bus.req = 1; mem_bus.addr_ok = 1;
        for (int k = 0; k < 2; k++) begin
            inst_bus.addr = 32'h1c000010 + 32'(4 * k);
            #1;
            checks++;
            if (inst_bus.addr_ok !== 1'b1) begin
                failures++;
                $display("FAIL full_fill%0d: inst_addr_ok=%b required 1", k, inst_bus.addr_ok);
            end
            sb.push_back('{who: 1'b0, rdata: 32'h11110000 * 32'(k + 1)});
            next_cycle();
        end
        inst_bus.addr = 32'h1c000018;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (mem_bus.req !== 1'b0 || inst_bus.addr_ok !== 1'b0) begin
                failures++;
                $display("FAIL full_block%0d: mem_req=%b inst_addr_ok=%b required 0/0",
                         c, mem_bus.req, inst_bus.addr_ok);
            end
            next_cycle();
        end
        e = sb.pop_front();
        mem_bus.data_ok = 1; mem_bus.rdata = e.rdata;
        #1;
        checks++;
        if (inst_bus.data_ok !== 1'b1 || inst_bus.rdata !== e.rdata || mem_bus.req !== 1'b0) begin
            failures++;
            $display("FAIL full_first_resp: inst_data_ok=%b inst_rdata=%h mem_req=%b required 1/%h/0",
                     inst_bus.data_ok, inst_bus.rdata, mem_bus.req, e.rdata);
        end
        next_cycle();
        mem_bus.data_ok = 0;
        #1;
        checks++;
        if (mem_bus.req !== 1'b1 || inst_bus.addr_ok !== 1'b1 || mem_bus.addr !== 32'h1c000018) begin
            failures++;
            $display("FAIL full_third: mem_req=%b inst_addr_ok=%b mem_addr=%h required 1/1/1c000018",
                     mem_bus.req, inst_bus.addr_ok, mem_bus.addr);
        end
        sb.push_back('{who: 1'b0, rdata: 32'h33330000});
        next_cycle();
        inst_bus.req = 0; mem_bus.addr_ok = 0;
        data_bus.req = 1; data_bus.addr = 32'h80000040;
        #1;
        checks++;
        if (dut.count !== 2'd2 || mem_bus.req !== 1'b0) begin
            failures++;
            $display("FAIL full_count: count=%0d mem_req=%b required 2/0", dut.count, mem_bus.req);
        end
        data_bus.req = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            mem_bus.data_ok = 1; mem_bus.rdata = e.rdata;
            #1;
            checks++;
            if (inst_bus.data_ok !== ~e.who || data_bus.data_ok !== e.who ||
                (e.who ? data_bus.rdata : inst_bus.rdata) !== e.rdata) begin
                failures++;
                $display("FAIL full_route: ok=%b%b rdata=%h/%h required owner %0d data %h",
                         inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata, data_bus.rdata, e.who, e.rdata);
            end
            next_cycle();
            mem_bus.data_ok = 0;
        end
    endtask

    task automatic test_push_pop();
        data_bus.req = 1; data_bus.addr = 32'h80003000; mem_bus.addr_ok = 1;
        sb.push_back('{who: 1'b1, rdata: 32'hCAFE0001});
        next_cycle();
        data_bus.req = 0;
        inst_bus.req = 1; inst_bus.addr = 32'h1c000300;
        e = sb.pop_front();
        mem_bus.data_ok = 1; mem_bus.rdata = e.rdata;
        #1;
        checks++;
        if (data_bus.data_ok !== 1'b1 || data_bus.rdata !== e.rdata || inst_bus.data_ok !== 1'b0 ||
            inst_bus.addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL pp_same_cycle: data_ok=%b data_rdata=%h inst_data_ok=%b inst_addr_ok=%b required 1/%h/0/1",
                     data_bus.data_ok, data_bus.rdata, inst_bus.data_ok, inst_bus.addr_ok, e.rdata);
        end
        sb.push_back('{who: 1'b0, rdata: 32'hBEEF0002});
        next_cycle();
        inst_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 0;
        #1;
        checks++;
        if (dut.count !== 2'd1) begin
            failures++;
            $display("FAIL pp_count: count=%0d required 1", dut.count);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            mem_bus.data_ok = 1; mem_bus.rdata = e.rdata;
            #1;
            checks++;
            if (inst_bus.data_ok !== ~e.who || data_bus.data_ok !== e.who ||
                (e.who ? data_bus.rdata : inst_bus.rdata) !== e.rdata ||
                (e.who ? inst_bus.rdata : data_bus.rdata) !== 32'h0) begin
                failures++;
                $display("FAIL pp_route: ok=%b%b rdata=%h/%h required owner %0d data %h",
                         inst_bus.data_ok, data_bus.data_ok, inst_bus.rdata, data_bus.rdata, e.who, e.rdata);
            end
            next_cycle();
            mem_bus.data_ok = 0;
        end
    endtask

    task automatic test_spurious_reset();
        mem_bus.data_ok = 1; mem_bus.rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL spur_route: inst_data_ok=%b data_data_ok=%b resp_err=%b required 0/0/0",
                     inst_bus.data_ok, data_bus.data_ok, resp_err);
        end
        next_cycle();
        mem_bus.data_ok = 0;
        #1;
        checks++;
        if (resp_err !== 1'b1) begin
            failures++;
            $display("FAIL spur_err: resp_err=%b required 1", resp_err);
        end
        inst_bus.req = 1; inst_bus.addr = 32'h1c000400; mem_bus.addr_ok = 1;
        next_cycle();
        inst_bus.addr = 32'h1c000404; mem_bus.addr_ok = 0;
        @(posedge clk);
        #3;
        resetn = 0;
        #1;
        checks++;
        if (mem_bus.req !== 1'b0 || mem_bus.addr !== 32'h0 || inst_bus.addr_ok !== 1'b0 ||
            resp_err !== 1'b0 || dut.count !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: mem_req=%b mem_addr=%h inst_addr_ok=%b resp_err=%b count=%0d required 0/0/0/0/0",
                     mem_bus.req, mem_bus.addr, inst_bus.addr_ok, resp_err, dut.count);
        end
        sb.delete();
        next_cycle();
        resetn = 1;
        inst_bus.req = 0;
        mem_bus.data_ok = 1; mem_bus.rdata = 32'h0BAD0BAD;
        #1;
        checks++;
        if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) begin
            failures++;
            $display("FAIL stale_route: inst_data_ok=%b data_data_ok=%b required 0/0",
                     inst_bus.data_ok, data_bus.data_ok);
        end
        next_cycle();
        mem_bus.data_ok = 0;
        #1;
        checks++;
        if (resp_err !== 1'b1) begin
            failures++;
            $display("FAIL stale_err: resp_err=%b required 1", resp_err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_inst();
        test_simultaneous();
        test_lock();
        test_full();
        test_push_pop();
        test_spurious_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
